// File: rtl/riscv_pkg.sv
// Shared opcode constants, enums and small decode helpers for the memory stage.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // {funct3, opcode[6:0]} encodings, the same layout the ALU forwards
    localparam logic [9:0] OPC_LB  = {3'b000, OP_LOAD};
    localparam logic [9:0] OPC_LH  = {3'b001, OP_LOAD};
    localparam logic [9:0] OPC_LW  = {3'b010, OP_LOAD};
    localparam logic [9:0] OPC_LD  = {3'b011, OP_LOAD};
    localparam logic [9:0] OPC_LBU = {3'b100, OP_LOAD};
    localparam logic [9:0] OPC_LHU = {3'b101, OP_LOAD};
    localparam logic [9:0] OPC_LWU = {3'b110, OP_LOAD};
    localparam logic [9:0] OPC_SB  = {3'b000, OP_STORE};
    localparam logic [9:0] OPC_SH  = {3'b001, OP_STORE};
    localparam logic [9:0] OPC_SW  = {3'b010, OP_STORE};
    localparam logic [9:0] OPC_SD  = {3'b011, OP_STORE};

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} mem_state_e;

    // Byte-enable pattern for an access of the given size at offset 0
    function automatic logic [7:0] size_mask(input mem_size_e size);
        unique case (size)
            MEM_B: size_mask = 8'h01;
            MEM_H: size_mask = 8'h03;
            MEM_W: size_mask = 8'h0F;
            MEM_D: size_mask = 8'hFF;
        endcase
    endfunction

    // An access is misaligned when the offset is not a multiple of its size
    function automatic logic misaligned(input mem_size_e size, input logic [2:0] off);
        unique case (size)
            MEM_B: misaligned = 1'b0;
            MEM_H: misaligned = off[0];
            MEM_W: misaligned = |off[1:0];
            MEM_D: misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed bytes of a 64-bit load response and extends them to XLEN.
module load_align
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] resp_data,
    input  logic [2:0]      byte_off,
    input  mem_size_e       size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // Shift the addressed byte down to lane 0, then sign- or zero-extend by size
    always_comb begin
        shifted = resp_data >> {byte_off, 3'b000};
        unique case (size)
            MEM_B: result = is_unsigned ? {{(XLEN-8){1'b0}},  shifted[7:0]}
                                        : {{(XLEN-8){shifted[7]}},  shifted[7:0]};
            MEM_H: result = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MEM_W: result = is_unsigned ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                                        : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            MEM_D: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store at a time and produces a writeback pulse.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
// in_valid/in_ready capture one ALU record; mem_req_valid stays high with all request
// fields stable until mem_req_ready; mem_resp_valid is a one-cycle pulse with no ready.
module mem_stage
    import riscv_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_result,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [XLEN-1:0]   in_sdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [7:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [XLEN-1:0]   mem_resp_data,
    output logic              wb_valid,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_err,
    output mem_state_e        dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    mem_state_e        state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic              store_q, store_d;
    mem_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic [2:0]        off_q, off_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   data_q, data_d;

    logic [2:0]        funct3;
    logic              is_load, is_store;
    mem_size_e         in_size;
    logic [XLEN-1:0]   load_res;

    assign funct3   = in_opcode[9:7];
    assign is_load  = (in_opcode[6:0] == OP_LOAD) && (funct3 != 3'b111);
    assign is_store = (in_opcode[6:0] == OP_STORE) && !funct3[2];
    assign in_size  = mem_size_e'(funct3[1:0]);

    load_align #(.XLEN(XLEN)) u_align (
        .resp_data   (mem_resp_data),
        .byte_off    (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (load_res)
    );

    // Next-state and captured-record decode
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rd_d    = in_rd;
                    store_d = is_store;
                    size_d  = in_size;
                    uns_d   = funct3[2];
                    off_d   = in_addr[2:0];
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    addr_d  = {in_addr[ADDR_W-1:3], 3'b000};
                    wdata_d = is_store ? (in_sdata << {in_addr[2:0], 3'b000}) : '0;
                    wstrb_d = is_store ? (size_mask(in_size) << in_addr[2:0]) : 8'h00;
                    data_d  = '0;
                    if (!(is_load || is_store)) begin
                        data_d  = in_result;
                        state_d = WB;
                    end else if (misaligned(in_size, in_addr[2:0])) begin
                        err_d   = 1'b1;
                        state_d = WB;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    if (mem_resp_valid) begin
                        data_d  = store_q ? '0 : load_res;
                        state_d = WB;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    data_d  = store_q ? '0 : load_res;
                    state_d = WB;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = WB;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: state_d = IDLE;
        endcase
    end

    // State and record registers; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rd_q    <= '0;
            store_q <= 1'b0;
            size_q  <= MEM_B;
            uns_q   <= 1'b0;
            off_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            store_q <= store_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            data_q  <= data_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_we    = (state_q == REQ) && store_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;
    assign wb_valid      = (state_q == WB);
    assign wb_err        = (state_q == WB) && err_q;
    assign wb_en         = (state_q == WB) && (rd_q != 5'd0) && !err_q && !store_q;
    assign wb_rd         = rd_q;
    assign wb_data       = data_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, backpressure, errors, reset.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [9:0]  in_opcode = '0;
    logic [4:0]  in_rd = '0;
    logic [63:0] in_result = '0;
    logic [63:0] in_addr = '0;
    logic [63:0] in_sdata = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_req_we;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_err;
    mem_state_e  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    mem_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_result(in_result), .in_addr(in_addr), .in_sdata(in_sdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_err(wb_err), .dbg_state(dbg_state)
    );

    // Clock and run-time guard
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare writeback data against the oldest expected value
    task automatic check_wb_data(input string tag);
        logic [63:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: writeback seen with empty expected queue, got 0x%0h", tag, wb_data);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, wb_data, exp);
        end
    endtask

    // Present one record at a negedge; returns at the next negedge after capture
    task automatic issue(input logic [9:0] op, input logic [4:0] rd, input logic [63:0] result,
                         input logic [63:0] addr, input logic [63:0] sdata);
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_result = result;
        in_addr   = addr;
        in_sdata  = sdata;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Full memory transaction; ends at the negedge where wb_valid should be high
    task automatic mem_op(input string tag, input logic [9:0] op, input logic [4:0] rd,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] resp, input int ready_delay, input bit same_cycle,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_wstrb, input bit exp_we);
        int lat;
        issue(op, rd, 64'h0, addr, sdata);
        lat = 1;
        check_eq({tag, " req_valid"}, 64'(mem_req_valid), 64'd1);
        check_eq({tag, " req_addr"}, mem_req_addr, exp_addr);
        check_eq({tag, " req_we"}, 64'(mem_req_we), 64'(exp_we));
        check_eq({tag, " req_wdata"}, mem_req_wdata, exp_wdata);
        check_eq({tag, " req_wstrb"}, 64'(mem_req_wstrb), 64'(exp_wstrb));
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            lat++;
            check_eq({tag, " hold valid"}, 64'(mem_req_valid), 64'd1);
            check_eq({tag, " hold addr"}, mem_req_addr, exp_addr);
            check_eq({tag, " hold wdata"}, mem_req_wdata, exp_wdata);
            check_eq({tag, " hold wstrb"}, 64'(mem_req_wstrb), 64'(exp_wstrb));
        end
        mem_req_ready = 1'b1;
        if (same_cycle) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = resp;
        end
        @(negedge clk);
        lat++;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (!same_cycle) begin
            check_eq({tag, " in WAIT"}, 64'(dbg_state), 64'(WAIT));
            mem_resp_valid = 1'b1;
            mem_resp_data  = resp;
            @(negedge clk);
            lat++;
            mem_resp_valid = 1'b0;
        end
        check_eq({tag, " wb_valid"}, 64'(wb_valid), 64'd1);
        check_eq({tag, " latency"}, 64'(lat), 64'(3 + ready_delay - (same_cycle ? 1 : 0)));
        check_wb_data({tag, " wb_data"});
    endtask

    initial begin
        int waits;
        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst in_ready", 64'(in_ready), 64'd1);
        check_eq("rst req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rst req_we", 64'(mem_req_we), 64'd0);
        check_eq("rst wb_valid", 64'(wb_valid), 64'd0);
        check_eq("rst wb_en", 64'(wb_en), 64'd0);
        check_eq("rst wb_err", 64'(wb_err), 64'd0);
        check_eq("rst wb_rd", 64'(wb_rd), 64'd0);
        check_eq("rst wb_data", wb_data, 64'd0);
        check_eq("rst req_addr", mem_req_addr, 64'd0);
        check_eq("rst req_wdata", mem_req_wdata, 64'd0);
        check_eq("rst req_wstrb", 64'(mem_req_wstrb), 64'd0);

        // Non-memory pass-through (ADDI)
        exp_q.push_back(64'h2A);
        issue({3'b000, 7'b0010011}, 5'd5, 64'h2A, 64'h0, 64'h0);
        check_eq("addi wb_valid", 64'(wb_valid), 64'd1);
        check_eq("addi wb_en", 64'(wb_en), 64'd1);
        check_eq("addi wb_rd", 64'(wb_rd), 64'd5);
        check_wb_data("addi wb_data");
        check_eq("addi req_valid", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        check_eq("addi pulse end", 64'(wb_valid), 64'd0);

        // LB / LBU at byte offset 3
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FF80);
        mem_op("lb", OPC_LB, 5'd7, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 1'b0,
               64'h1000, 64'h0, 8'h00, 1'b0);
        check_eq("lb wb_en", 64'(wb_en), 64'd1);
        check_eq("lb wb_rd", 64'(wb_rd), 64'd7);
        @(negedge clk);
        exp_q.push_back(64'h80);
        mem_op("lbu", OPC_LBU, 5'd8, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 1'b0,
               64'h1000, 64'h0, 8'h00, 1'b0);
        @(negedge clk);

        // LW sign extension at offset 4, LHU at offset 2
        exp_q.push_back(64'hFFFF_FFFF_8000_0001);
        mem_op("lw", OPC_LW, 5'd9, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 0, 1'b0,
               64'h1000, 64'h0, 8'h00, 1'b0);
        @(negedge clk);
        exp_q.push_back(64'h0000_0000_0000_ABCD);
        mem_op("lhu", OPC_LHU, 5'd10, 64'h1002, 64'h0, 64'h0000_0000_ABCD_0000, 0, 1'b0,
               64'h1000, 64'h0, 8'h00, 1'b0);
        @(negedge clk);

        // Stores: SH at offset 6, SW at offset 4
        exp_q.push_back(64'h0);
        mem_op("sh", OPC_SH, 5'd3, 64'h2006, 64'hBEEF, 64'h0, 0, 1'b0,
               64'h2000, 64'hBEEF_0000_0000_0000, 8'hC0, 1'b1);
        check_eq("sh wb_en", 64'(wb_en), 64'd0);
        check_eq("sh wb_err", 64'(wb_err), 64'd0);
        @(negedge clk);
        exp_q.push_back(64'h0);
        mem_op("sw", OPC_SW, 5'd4, 64'h2004, 64'h1234_5678, 64'h0, 0, 1'b0,
               64'h2000, 64'h1234_5678_0000_0000, 8'hF0, 1'b1);
        check_eq("sw wb_en", 64'(wb_en), 64'd0);
        @(negedge clk);

        // Backpressure: ready low for 5 cycles, response together with ready
        exp_q.push_back(64'h1122_3344_5566_7788);
        mem_op("ld bp", OPC_LD, 5'd11, 64'h3000, 64'h0, 64'h1122_3344_5566_7788, 5, 1'b1,
               64'h3000, 64'h0, 8'h00, 1'b0);
        check_eq("ld bp wb_en", 64'(wb_en), 64'd1);
        @(negedge clk);

        // Load to x0 completes without a register write
        exp_q.push_back(64'h55);
        mem_op("lb x0", OPC_LB, 5'd0, 64'h1000, 64'h0, 64'h55, 0, 1'b0,
               64'h1000, 64'h0, 8'h00, 1'b0);
        check_eq("lb x0 wb_en", 64'(wb_en), 64'd0);
        @(negedge clk);

        // Misaligned LW: no request, error one cycle after capture
        issue(OPC_LW, 5'd12, 64'h0, 64'h1002, 64'h0);
        check_eq("mis req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("mis wb_valid", 64'(wb_valid), 64'd1);
        check_eq("mis wb_err", 64'(wb_err), 64'd1);
        check_eq("mis wb_en", 64'(wb_en), 64'd0);
        @(negedge clk);

        // LD timeout: no response, then a stray response is ignored
        issue(OPC_LD, 5'd13, 64'h0, 64'h4000, 64'h0);
        check_eq("to req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        waits = 0;
        while (!wb_valid && waits < 400) begin
            waits++;
            @(negedge clk);
        end
        check_eq("to wait cycles", 64'(waits), 64'd255);
        check_eq("to wb_err", 64'(wb_err), 64'd1);
        check_eq("to wb_en", 64'(wb_en), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hDEAD;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check_eq("stray wb_valid", 64'(wb_valid), 64'd0);
        check_eq("stray in_ready", 64'(in_ready), 64'd1);

        // Reset during WAIT, then a late response
        issue(OPC_LD, 5'd14, 64'h0, 64'h5000, 64'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check_eq("rw in WAIT", 64'(dbg_state), 64'(WAIT));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rw req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("rw in_ready", 64'(in_ready), 64'd1);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 64'hBAD;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rw no wb", 64'(wb_valid), 64'd0);
            @(negedge clk);
        end

        check_eq("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
